// File: rtl/hsstl_rate_chg_ctrl_v1_0_pkg.sv
// Shared definitions for the HSST TX line-rate change sequencer:
// state encoding, default PMA rate codes and the rate-to-code mapping.
package hsstl_rate_chg_ctrl_v1_0_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLK_OFF   = 4'd1,
        ST_PMA_RST   = 4'd2,
        ST_RATE_SET  = 4'd3,
        ST_PMA_REL   = 4'd4,
        ST_WAIT_LOCK = 4'd5,
        ST_SETTLE    = 4'd6,
        ST_PCS_REL   = 4'd7,
        ST_CLK_ON    = 4'd8,
        ST_HALT      = 4'd9
    } rc_state_e;

    localparam logic [2:0] GEN1_CODE_DFLT = 3'b011;
    localparam logic [2:0] GEN2_CODE_DFLT = 3'b010;

    function automatic logic [2:0] rate_code(input logic       rate,
                                             input logic [2:0] gen1_code,
                                             input logic [2:0] gen2_code);
        return rate ? gen2_code : gen1_code;
    endfunction

endpackage

// File: rtl/hsstl_rate_chg_ctrl_v1_0.sv
// PCIe TX rate-change sequencer: gates TXPCLK, resets PMA/PCS around a rate-code
// change, waits for PLL re-lock (one revert-retry on timeout), then restores the clock.
module hsstl_rate_chg_ctrl_v1_0
    import hsstl_rate_chg_ctrl_v1_0_pkg::*;
#(
    parameter int         CNTR_WIDTH       = 13,
    parameter int         CLK_OFF_CYC      = 16,
    parameter int         RST_HOLD_CYC     = 32,
    parameter int         SETTLE_CYC       = 64,
    parameter int         LOCK_TIMEOUT_CYC = 4096,
    parameter logic [2:0] RATE_GEN1_CODE   = GEN1_CODE_DFLT,
    parameter logic [2:0] RATE_GEN2_CODE   = GEN2_CODE_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rate_req,
    input  logic       tx_rst_done,
    input  logic       pll_lock_deb,
    output logic       P_RATE_CHG_TXPCLK_ON,
    output logic [2:0] P_PMA_TX_RATE,
    output logic       P_PMA_TX_RST,
    output logic       P_PCS_TX_RST,
    output logic       rate_cur,
    output logic       rate_chg_busy,
    output logic       rate_chg_done,
    output logic       rate_chg_err
);

    localparam logic [CNTR_WIDTH-1:0] L_CLK_OFF_LAST = CNTR_WIDTH'(CLK_OFF_CYC - 1);
    localparam logic [CNTR_WIDTH-1:0] L_HOLD_LAST    = CNTR_WIDTH'(RST_HOLD_CYC - 1);
    localparam logic [CNTR_WIDTH-1:0] L_SETTLE_LAST  = CNTR_WIDTH'(SETTLE_CYC - 1);
    localparam logic [CNTR_WIDTH-1:0] L_LOCK_LAST    = CNTR_WIDTH'(LOCK_TIMEOUT_CYC - 1);

    rc_state_e             r_state;
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic                  r_tgt;
    logic                  r_retry;
    logic                  r_clk_on;
    logic [2:0]            r_rate_code;
    logic                  r_pma_rst;
    logic                  r_pcs_rst;
    logic                  r_rate_cur;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [CNTR_WIDTH-1:0] w_cnt_inc;
    logic [2:0]            w_set_code;
    logic [2:0]            w_cur_code;
    logic                  w_accept;
    logic                  w_abort;

    always_comb begin
        w_cnt_inc  = r_cnt + CNTR_WIDTH'(1);
        w_cur_code = rate_code(r_rate_cur, RATE_GEN1_CODE, RATE_GEN2_CODE);
        // A retry pass reprograms the rate that was in effect before the request.
        w_set_code = r_retry ? w_cur_code
                             : rate_code(r_tgt, RATE_GEN1_CODE, RATE_GEN2_CODE);
        w_accept   = tx_rst_done && pll_lock_deb && (rate_req != r_rate_cur);
        w_abort    = (r_state != ST_IDLE) && !tx_rst_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tgt       <= 1'b0;
            r_retry     <= 1'b0;
            r_clk_on    <= 1'b1;
            r_rate_code <= RATE_GEN1_CODE;
            r_pma_rst   <= 1'b0;
            r_pcs_rst   <= 1'b0;
            r_rate_cur  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_clk_on    <= 1'b1;
                r_pma_rst   <= 1'b0;
                r_pcs_rst   <= 1'b0;
                r_busy      <= 1'b0;
                r_rate_code <= w_cur_code;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state  <= ST_CLK_OFF;
                            r_cnt    <= '0;
                            r_tgt    <= rate_req;
                            r_err    <= 1'b0;
                            r_retry  <= 1'b0;
                            r_clk_on <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_CLK_OFF: begin
                        if (r_cnt == L_CLK_OFF_LAST) begin
                            r_state   <= ST_PMA_RST;
                            r_cnt     <= '0;
                            r_pma_rst <= 1'b1;
                            r_pcs_rst <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_PMA_RST: begin
                        r_state     <= ST_RATE_SET;
                        r_cnt       <= '0;
                        r_rate_code <= w_set_code;
                    end
                    ST_RATE_SET: begin
                        if (r_cnt == L_HOLD_LAST) begin
                            r_state <= ST_PMA_REL;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_PMA_REL: begin
                        r_state   <= ST_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pma_rst <= 1'b0;
                    end
                    ST_WAIT_LOCK: begin
                        if (pll_lock_deb) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == L_LOCK_LAST) begin
                            r_cnt     <= '0;
                            r_pma_rst <= 1'b1;
                            r_pcs_rst <= 1'b1;
                            if (!r_retry) begin
                                r_state <= ST_PMA_RST;
                                r_err   <= 1'b1;
                                r_retry <= 1'b1;
                            end else begin
                                r_state  <= ST_HALT;
                                r_clk_on <= 1'b0;
                                r_busy   <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_SETTLE: begin
                        if (!pll_lock_deb) begin
                            r_state <= ST_WAIT_LOCK;
                            r_cnt   <= '0;
                        end else if (r_cnt == L_SETTLE_LAST) begin
                            r_state <= ST_PCS_REL;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_PCS_REL: begin
                        r_cnt <= '0;
                        if (!pll_lock_deb) begin
                            r_state <= ST_WAIT_LOCK;
                        end else begin
                            r_state   <= ST_CLK_ON;
                            r_pcs_rst <= 1'b0;
                        end
                    end
                    ST_CLK_ON: begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_clk_on <= 1'b1;
                        r_busy   <= 1'b0;
                        if (!r_retry) begin
                            r_rate_cur <= r_tgt;
                            r_done     <= 1'b1;
                        end
                    end
                    // Parked with the lane held in reset until the TX reset FSM restarts.
                    ST_HALT: begin
                        r_state <= ST_HALT;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign P_RATE_CHG_TXPCLK_ON = r_clk_on;
    assign P_PMA_TX_RATE        = r_rate_code;
    assign P_PMA_TX_RST         = r_pma_rst;
    assign P_PCS_TX_RST         = r_pcs_rst;
    assign rate_cur             = r_rate_cur;
    assign rate_chg_busy        = r_busy;
    assign rate_chg_done        = r_done;
    assign rate_chg_err         = r_err;

endmodule

// File: doc/hsstl_rate_chg_ctrl_v1_0.md
Name: hsstl_rate_chg_ctrl_v1_0

Overview:
- Sequences a PCIe TX line-rate change (2.5 <-> 5.0 GT/s) on the HSST lanes after the TX reset FSM has completed.
- Gates the TX parallel clock, resets the PMA TX, reprograms the rate code, waits for PLL re-lock, releases the PMA and PCS resets, then re-enables the clock.
- Sits between the MAC rate request and the per-lane TX rate and reset controls; its outputs are fanned out to all four lanes.

Parameters:
- CNTR_WIDTH, 13, width of the shared phase/timeout counter.
- CLK_OFF_CYC, 16, cycles the TXPCLK is held off before the PMA reset.
- RST_HOLD_CYC, 32, cycles the PMA TX reset is held after the rate code changes.
- SETTLE_CYC, 64, cycles after the PMA release before the PCS release.
- LOCK_TIMEOUT_CYC, 4096, maximum wait for PLL lock; must be < 2^CNTR_WIDTH.
- RATE_GEN1_CODE, 3'b011, P_PMA_TX_RATE value for 2.5 GT/s.
- RATE_GEN2_CODE, 3'b010, P_PMA_TX_RATE value for 5.0 GT/s.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rate_req  in  1  requested rate (0 = 2.5, 1 = 5.0 GT/s), level, clk domain.
- tx_rst_done  in  1  TX reset FSM complete.
- pll_lock_deb  in  1  debounced, synchronised PLL lock.
- P_RATE_CHG_TXPCLK_ON  out  1  TXPCLK enable during a rate change.
- P_PMA_TX_RATE  out  3  PMA TX rate code.
- P_PMA_TX_RST  out  1  PMA TX reset.
- P_PCS_TX_RST  out  1  PCS TX reset.
- rate_cur  out  1  rate currently in effect.
- rate_chg_busy  out  1  sequence in progress.
- rate_chg_done  out  1  one-cycle pulse on successful completion.
- rate_chg_err  out  1  sticky lock-timeout flag.

Behaviour:
- Reset values: TXPCLK_ON=1, P_PMA_TX_RATE=RATE_GEN1_CODE, PMA_TX_RST=0, PCS_TX_RST=0, rate_cur=0, busy=0, done=0, err=0, state=IDLE, counter=0, retry=0.
- All outputs are registered. The counter clears on every state entry.
- IDLE:
  - Accept when tx_rst_done & pll_lock_deb & (rate_req != rate_cur).
  - On accept, latch tgt=rate_req, clear err and retry, and go to CLK_OFF.
  - busy rises in the cycle after the accepting edge.
- CLK_OFF: TXPCLK_ON=0. After CLK_OFF_CYC cycles, go to PMA_RST.
- PMA_RST: PMA_TX_RST=1, PCS_TX_RST=1. Next cycle go to RATE_SET.
- RATE_SET: P_PMA_TX_RATE = code(tgt), or code(rate_cur) when retry=1. Hold RST_HOLD_CYC cycles, then go to PMA_REL.
- PMA_REL: PMA_TX_RST=0. Go to WAIT_LOCK.
- WAIT_LOCK:
  - If pll_lock_deb=1, go to SETTLE.
  - If the counter reaches LOCK_TIMEOUT_CYC-1 with no lock:
    - with retry=0: set err=1, set retry=1, go to PMA_RST (reverts to the old rate);
    - with retry=1: go to HALT.
- SETTLE: wait SETTLE_CYC cycles, then go to PCS_REL.
- PCS_REL: PCS_TX_RST=0. Go to CLK_ON.
- CLK_ON:
  - TXPCLK_ON=1.
  - If retry=0: rate_cur<=tgt, pulse done.
  - If retry=1: rate_cur unchanged, no done pulse.
  - Then go to IDLE. busy falls in the cycle after CLK_ON.
- HALT: TXPCLK_ON=0, both resets=1, busy=1. Only rst or tx_rst_done falling exits HALT.
- Abort: tx_rst_done=0 in any non-IDLE state → next cycle IDLE, with TXPCLK_ON=1, resets=0, busy=0. P_PMA_TX_RATE=code(rate_cur); rate_cur and err are kept.
- rate_req is ignored while busy. A change during the sequence is re-evaluated in IDLE; a toggle back to rate_cur before IDLE produces no new sequence.
- pll_lock_deb falling in SETTLE or PCS_REL: go back to WAIT_LOCK, counter cleared, resets unchanged.
- Nominal latency, accept to done with immediate lock: 1+CLK_OFF_CYC+1+RST_HOLD_CYC+1+1+SETTLE_CYC+1+1 cycles.

Decomposition:
- Shared package: state enumeration (IDLE, CLK_OFF, PMA_RST, RATE_SET, PMA_REL, WAIT_LOCK, SETTLE, PCS_REL, CLK_ON, HALT; 4-bit encoding) and the rate code constants.
- No sub-module. The FSM and single counter are one always-block pair.
- Lane fan-out stays in the parent.

Test Plan:
- Reset, then tx_rst_done=1, lock=1, rate_req 0→1:
  - TXPCLK_ON low for 16 cycles, PMA_RST high 34 cycles;
  - rate code becomes 3'b010;
  - done pulses at accept+118 with lock held; rate_cur=1, busy=0.
- Lock drops for 100 cycles during WAIT_LOCK, then returns: sequence stalls exactly 100 extra cycles, completes, err=0.
- Lock never returns:
  - after 4096 cycles err=1, code reverts to 3'b011;
  - second timeout enters HALT (busy=1, TXPCLK_ON=0);
  - dropping tx_rst_done returns to IDLE.
- tx_rst_done falls mid-RATE_SET: next cycle resets=0, TXPCLK_ON=1, code=3'b011, busy=0, no done.
- rate_req toggles 1→0→1 while busy from 0→1: one done pulse only, rate_cur=1, no second sequence.
- rate_req=1 asserted while tx_rst_done=0: no activity until tx_rst_done rises, then the sequence starts next cycle.
